seq_detect_prog: RTL
====================

# seq_detect_prog

Runtime-programmable serial pattern detector. It replaces the fixed 4-bit "1011" detector with a configurable pattern of 1..MAX_LEN bits, a selectable overlap mode, input qualification, and a saturating match counter. It sits on a serial bit stream in the same clock domain as the producer. Configuration is loaded from a control register block.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 4..32.
- CNT_W, 8: width of match_count; legal range 1..32.
- LEN_W is a localparam equal to $clog2(MAX_LEN+1). It is not overridable.

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- inp_bit  in  1  serial data bit.
- inp_valid  in  1  inp_bit is sampled only on edges where this is 1.
- pat_load  in  1  latch pat_value, pat_len and overlap_en on this edge.
- pat_value  in  MAX_LEN  pattern. Bit pat_len-1 is the first bit received; bit 0 is the last. Bits at pat_len and above are ignored.
- pat_len  in  LEN_W  pattern length.
- overlap_en  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cnt_clr  in  1  clear match_count.
- seq_seen  out  1  registered one-cycle pulse per match.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky flag: an illegal pat_len load was rejected.

## Operation
- Active configuration registers: pattern, length and overlap mode.
  - Reset values: pattern = 1011 in the low 4 bits, length = 4, overlap = 1.
  - With these values the block behaves exactly as the legacy 1011 detector.
- History register hist[MAX_LEN-1:0] and fill counter fill (0..MAX_LEN).
  - On an accepted bit: hist <= {hist[MAX_LEN-2:0], inp_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition on an accepted bit, evaluated on the post-shift values:
  - fill_next >= len, and
  - hist_next[len-1:0] == pattern[len-1:0].
- On a match:
  - seq_seen is 1 in the following cycle.
  - match_count increments and saturates at 2^CNT_W-1.
  - If overlap = 0, fill <= 0, so the next match needs len fresh bits.
  - If overlap = 1, fill is updated normally.
- pat_load with 1 <= pat_len <= MAX_LEN:
  - Latches the configuration.
  - Clears hist and fill.
  - Ignores inp_bit on the same edge; no match can occur on that edge.
  - Leaves match_count unchanged.
- pat_load with pat_len = 0 or pat_len > MAX_LEN:
  - Configuration, hist and fill are unchanged.
  - cfg_err <= 1.
  - The bit on that edge is processed normally.
- cfg_err clears only on reset.
- cnt_clr: match_count <= 0. If a match occurs on the same edge, match_count <= 1. The clear applies first, then the match is counted.
- Edges with inp_valid = 0: hist, fill and config hold (apart from any load); seq_seen is 0 the next cycle.

## Timing
- All outputs are registered.
- Reset values: seq_seen = 0, match_count = 0, cfg_err = 0, hist = 0, fill = 0, config = defaults.
- Reset has priority over every other input on the same edge.
- Reset mid-sequence discards all partial history, and any match that would have completed on that edge. No seq_seen pulse follows.
- Latency: the completing bit is sampled at edge N; seq_seen = 1 for exactly the cycle N..N+1, and match_count shows the new value from edge N.
- Back-to-back matches (overlap mode with a periodic pattern, or len = 1) give seq_seen high on consecutive cycles, one cycle per match.
- pat_load priority is reset > pat_load > bit processing. cnt_clr is independent of pat_load.
- match_count saturation: a match at max value leaves the count at max and still pulses seq_seen.

## Test plan
- Defaults, overlap. After reset, stream 1011011 (all valid) -> seq_seen pulses after bits 4 and 7; match_count = 2.
- Non-overlap. Load pattern 1011, len 4, overlap 0; stream 1011011011 -> pulses after bits 4 and 10 only, count = 2. Repeat with overlap 1 -> pulses after bits 4, 7 and 10, count = 3.
- Full length with gaps. MAX_LEN = 8; load 11001010, len 8; drive the bits with inp_valid = 0 on alternate cycles -> one pulse, one cycle after the 8th valid bit. A 7-bit prefix then reset -> no pulse.
- Illegal load. pat_load with pat_len = 0, then with pat_len = 9 (MAX_LEN = 8) -> cfg_err = 1; stream 1011 -> match using the prior config; cfg_err stays 1 until reset.
- Counter. CNT_W = 4; produce 17 matches -> count = 15, and a seq_seen pulse on every match. Assert cnt_clr on the edge of a match -> count = 1.
- Length 1. Load pattern 1, len 1; stream 111 -> seq_seen high for 3 consecutive cycles, count = 3. Drive pat_load on the same edge as a valid 1 -> that bit is ignored, no pulse.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap control,
// input qualification, sticky config-error flag and saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_value,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               cnt_clr,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(4);
  localparam logic [MAX_LEN-1:0] DEF_PATTERN = {{(MAX_LEN-4){1'b0}}, 4'b1011};
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  // Only MAX_LEN-1 bits need storing: the newest bit arrives on the
  // same edge the comparison is made.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               seq_seen_q, seq_seen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               load_ok;
  logic               load_bad;
  logic               match;
  logic [CNT_W-1:0]   cnt_base;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end
  endgenerate

  assign hist_next = {hist_q, inp_bit};
  assign fill_next = (fill_q == MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);
  assign load_ok   = pat_load && (pat_len != '0) && (pat_len <= MAX_LEN_L);
  assign load_bad  = pat_load && !load_ok;

  always_comb begin
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    cfg_err_d  = cfg_err_q;
    match      = 1'b0;
    cnt_base   = cnt_q;
    cnt_d      = cnt_q;

    if (load_ok) begin
      pat_d  = pat_value;
      len_d  = pat_len;
      ovl_d  = overlap_en;
      hist_d = '0;
      fill_d = '0;
    end else if (inp_valid) begin
      match  = (fill_next >= len_q) &&
               (((hist_next ^ pat_q) & len_mask) == '0);
      hist_d = hist_next[MAX_LEN-2:0];
      // Non-overlap mode restarts the fill so the next match needs len fresh bits.
      fill_d = (match && !ovl_q) ? '0 : fill_next;
    end

    if (load_bad) begin
      cfg_err_d = 1'b1;
    end

    if (cnt_clr) begin
      cnt_base = '0;
    end
    cnt_d = (match && (cnt_base != CNT_MAX)) ? cnt_base + CNT_W'(1) : cnt_base;

    seq_seen_d = match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q      <= DEF_PATTERN;
      len_q      <= DEF_LEN;
      ovl_q      <= 1'b1;
      hist_q     <= '0;
      fill_q     <= '0;
      seq_seen_q <= 1'b0;
      cnt_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      seq_seen_q <= seq_seen_d;
      cnt_q      <= cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign seq_seen    = seq_seen_q;
  assign match_count = cnt_q;
  assign cfg_err     = cfg_err_q;

endmodule
